// File: rtl/spi_flash_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_flash_responder_pkg
//  Purpose  : Shared opcodes, frame lengths and FSM state encoding for the
//             SPI flash responder.
//  Revision : 1.0  initial release
// ============================================================================
package spi_flash_responder_pkg;

   localparam logic [7:0] CMD_READ     = 8'h03;
   localparam logic [7:0] CMD_DREAD    = 8'h3B;
   localparam int         ADDR_BITS    = 24;
   localparam int         DUMMY_CYCLES = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_DATA   = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_flash_responder_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_edge_sync
//  Purpose  : Two-flop synchronizer with single-clk rise/fall pulses taken
//             from the synchronized copy.
//  Revision : 1.0  initial release
// ============================================================================
module spi_edge_sync
   import spi_flash_responder_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Metastability stages plus one history flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= d;
         sync <= meta;
         prev <= sync;
      end
   end

   assign q    = sync;
   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_flash_responder
//  Purpose  : SPI mode-0 flash device model serving READ (0x03) from a
//             preloadable byte array; dual-output read (0x3B) is available
//             when SPI_DUAL_READ_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module spi_flash_responder
   import spi_flash_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spi_cs,
   input  logic          spi_sclk,
   input  logic          spi_io0_i,
   output logic          spi_io0_o,
   output logic          spi_io0_oe,
   output logic          spi_io1_o,
   output logic          spi_io1_oe,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   output logic          busy
);

   logic cs_s, cs_rise, cs_fall;
   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic io0_meta, io0_s;

   logic [7:0]    mem [DEPTH];
   state_t        state, state_d;
   logic [4:0]    bit_cnt, bit_cnt_d;
   logic [7:0]    cmd, cmd_d;
   logic [AW-1:0] addr, addr_d;
   logic [7:0]    dout, dout_d;
   logic          io1_drv, io1_drv_d, io1_en, io1_en_d;
   logic [7:0]    cmd_shift;
   logic [AW-1:0] addr_shift, addr_inc;
   logic          byte_done;
`ifdef SPI_DUAL_READ_EN
   logic          dual, dual_d;
   logic          io0_drv, io0_drv_d, io0_en, io0_en_d;
`endif

   // Chip select idles high so reset must not fake a falling edge
   spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_level_unused),
      .rise(sclk_rise), .fall(sclk_fall)
   );

   // io0 only needs the level, aligned with the sclk pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io0_meta <= 1'b0;
         io0_s    <= 1'b0;
      end else begin
         io0_meta <= spi_io0_i;
         io0_s    <= io0_meta;
      end
   end

   // Backing store preload; contents survive reset
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
   end

   assign cmd_shift  = {cmd[6:0], io0_s};
   assign addr_shift = {addr[AW-2:0], io0_s};
   assign addr_inc   = addr + 1'b1;

   // Next-state and datapath decode for the serial protocol
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      cmd_d     = cmd;
      addr_d    = addr;
      dout_d    = dout;
      io1_drv_d = io1_drv;
      io1_en_d  = io1_en;
      byte_done = 1'b0;
`ifdef SPI_DUAL_READ_EN
      dual_d    = dual;
      io0_drv_d = io0_drv;
      io0_en_d  = io0_en;
`endif
      if (cs_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         io1_drv_d = 1'b0;
         io1_en_d  = 1'b0;
`ifdef SPI_DUAL_READ_EN
         io0_drv_d = 1'b0;
         io0_en_d  = 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  cmd_d     = cmd_shift;
                  bit_cnt_d = bit_cnt + 1'b1;
                  if (bit_cnt == 5'd7) begin
                     bit_cnt_d = '0;
                     if (cmd_shift == CMD_READ) begin
                        state_d = ST_ADDR;
`ifdef SPI_DUAL_READ_EN
                        dual_d  = 1'b0;
`endif
                     end
`ifdef SPI_DUAL_READ_EN
                     else if (cmd_shift == CMD_DREAD) begin
                        state_d = ST_ADDR;
                        dual_d  = 1'b1;
                     end
`endif
                     else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_ADDR: begin
               // Upper address bits fall off the top of the shift register
               if (sclk_rise) begin
                  addr_d    = addr_shift;
                  bit_cnt_d = bit_cnt + 1'b1;
                  if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                     bit_cnt_d = '0;
                     dout_d    = mem[addr_shift];
                     state_d   = ST_DATA;
`ifdef SPI_DUAL_READ_EN
                     if (dual) state_d = ST_DUMMY;
`endif
                  end
               end
            end
            ST_DUMMY: begin
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt + 1'b1;
                  if (bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (sclk_fall) begin
                  io1_drv_d = dout[7];
                  io1_en_d  = 1'b1;
                  bit_cnt_d = bit_cnt + 1'b1;
`ifdef SPI_DUAL_READ_EN
                  if (dual) begin
                     io0_drv_d = dout[6];
                     io0_en_d  = 1'b1;
                     dout_d    = {dout[5:0], 2'b00};
                     byte_done = (bit_cnt == 5'd3);
                  end else begin
                     dout_d    = {dout[6:0], 1'b0};
                     byte_done = (bit_cnt == 5'd7);
                  end
`else
                  dout_d    = {dout[6:0], 1'b0};
                  byte_done = (bit_cnt == 5'd7);
`endif
                  // Prefetch the next byte while the last bit goes out
                  if (byte_done) begin
                     bit_cnt_d = '0;
                     addr_d    = addr_inc;
                     dout_d    = mem[addr_inc];
                  end
               end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         cmd     <= '0;
         addr    <= '0;
         dout    <= '0;
         io1_drv <= 1'b0;
         io1_en  <= 1'b0;
`ifdef SPI_DUAL_READ_EN
         dual    <= 1'b0;
         io0_drv <= 1'b0;
         io0_en  <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         bit_cnt <= bit_cnt_d;
         cmd     <= cmd_d;
         addr    <= addr_d;
         dout    <= dout_d;
         io1_drv <= io1_drv_d;
         io1_en  <= io1_en_d;
`ifdef SPI_DUAL_READ_EN
         dual    <= dual_d;
         io0_drv <= io0_drv_d;
         io0_en  <= io0_en_d;
`endif
      end
   end

   assign spi_io1_o  = io1_drv;
   assign spi_io1_oe = io1_en;
`ifdef SPI_DUAL_READ_EN
   assign spi_io0_o  = io0_drv;
   assign spi_io0_oe = io0_en;
`else
   assign spi_io0_o  = 1'b0;
   assign spi_io0_oe = 1'b0;
`endif
   assign busy = ~cs_s;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_flash_responder
//  Purpose  : Scoreboard bench for spi_flash_responder (SPI_DUAL_READ_EN
//             selects the dual-read expectations).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_responder;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int HALF  = 50;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spi_cs = 1'b1;
   logic          spi_sclk = 1'b0;
   logic          spi_io0_i = 1'b0;
   logic          spi_io0_o, spi_io0_oe, spi_io1_o, spi_io1_oe, busy;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb [$];
   logic       last_oe0, last_oe1;
   logic       any_oe;

   spi_flash_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
      .spi_io0_i(spi_io0_i), .spi_io0_o(spi_io0_o), .spi_io0_oe(spi_io0_oe),
      .spi_io1_o(spi_io1_o), .spi_io1_oe(spi_io1_oe), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // One sclk period; outputs sampled just before the rising edge
   task automatic sclk_cycle(input logic mosi, output logic s0, output logic s1);
      spi_io0_i = mosi;
      #(HALF - 1);
      s0 = spi_io0_o; s1 = spi_io1_o;
      last_oe0 = spi_io0_oe; last_oe1 = spi_io1_oe;
      any_oe = any_oe | spi_io0_oe | spi_io1_oe;
      #1 spi_sclk = 1'b1;
      #HALF spi_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic a, c;
      for (int i = 7; i >= 0; i--) sclk_cycle(b[i], a, c);
   endtask

   task automatic idle_cycles(input int n);
      logic a, c;
      for (int i = 0; i < n; i++) sclk_cycle(1'b0, a, c);
   endtask

   task automatic begin_xfer();
      @(negedge clk);
      spi_cs = 1'b0;
      any_oe = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic end_xfer();
      repeat (2) @(negedge clk);
      spi_cs = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [23:0] a);
      send_byte(op);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic read_bytes(input int n, input bit dual, input string tag);
      logic s0, s1;
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         logic [7:0] exp;
         logic       oe_all;
         b = '0; oe_all = 1'b1;
         if (dual) begin
            for (int i = 0; i < 4; i++) begin
               sclk_cycle(1'b0, s0, s1);
               b = {b[5:0], s1, s0};
               oe_all = oe_all & last_oe1 & last_oe0;
            end
         end else begin
            for (int i = 0; i < 8; i++) begin
               sclk_cycle(1'b0, s0, s1);
               b = {b[6:0], s1};
               oe_all = oe_all & last_oe1;
            end
         end
         exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
         check_val($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, exp});
         check_val($sformatf("%s_oe%0d", tag, k), {31'd0, oe_all}, 32'd1);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_io0_o",  {31'd0, spi_io0_o},  32'd0);
      check_val("rst_io0_oe", {31'd0, spi_io0_oe}, 32'd0);
      check_val("rst_io1_o",  {31'd0, spi_io1_o},  32'd0);
      check_val("rst_io1_oe", {31'd0, spi_io1_oe}, 32'd0);
      check_val("rst_busy",   {31'd0, busy},       32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      load(8'h10, 8'hA5); load(8'h11, 8'h3C); load(8'h12, 8'hFF); load(8'h13, 8'h00);
      load(8'hFF, 8'h11); load(8'h00, 8'h22);

      // Plain read of four bytes
      sb.push_back(8'hA5); sb.push_back(8'h3C); sb.push_back(8'hFF); sb.push_back(8'h00);
      begin_xfer();
      send_cmd(8'h03, 24'h000010);
      check_val("t1_oe_before_data", {31'd0, last_oe1}, 32'd0);
      read_bytes(4, 1'b0, "t1");
      check_val("t1_busy_active", {31'd0, busy}, 32'd1);
      end_xfer();
      check_val("t1_oe_after_cs", {31'd0, spi_io1_oe}, 32'd0);
      check_val("t1_busy_idle", {31'd0, busy}, 32'd0);

      // Upper address bits ignored, wrap from top of array
      sb.push_back(8'h11); sb.push_back(8'h22);
      begin_xfer();
      send_cmd(8'h03, 24'hAB00FF);
      read_bytes(2, 1'b0, "t2");
      end_xfer();

      // Unknown opcode never drives
      begin_xfer();
      send_byte(8'h9F);
      idle_cycles(40);
      check_val("t3_no_drive", {31'd0, any_oe}, 32'd0);
      check_val("t3_busy", {31'd0, busy}, 32'd1);
      end_xfer();
      check_val("t3_busy_idle", {31'd0, busy}, 32'd0);

      // Abort mid-address, then a clean read
      begin_xfer();
      send_byte(8'h03);
      send_byte(8'h00);
      idle_cycles(4);
      end_xfer();
      sb.push_back(8'hA5);
      begin_xfer();
      send_cmd(8'h03, 24'h000010);
      read_bytes(1, 1'b0, "t4");
      end_xfer();

      // Asynchronous reset mid-data
      sb.push_back(8'hA5);
      begin_xfer();
      send_cmd(8'h03, 24'h000010);
      read_bytes(1, 1'b0, "t5a");
      idle_cycles(3);
      #7 rst = 1'b1;
      #1;
      check_val("t5_rst_io1_oe", {31'd0, spi_io1_oe}, 32'd0);
      check_val("t5_rst_io1_o",  {31'd0, spi_io1_o},  32'd0);
      check_val("t5_rst_busy",   {31'd0, busy},       32'd0);
      spi_cs = 1'b1;
      spi_sclk = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      sb.push_back(8'h3C);
      begin_xfer();
      send_cmd(8'h03, 24'h000011);
      read_bytes(1, 1'b0, "t5b");
      end_xfer();

      // Dual-output read
      begin_xfer();
      send_cmd(8'h3B, 24'h000010);
`ifdef SPI_DUAL_READ_EN
      sb.push_back(8'hA5);
      idle_cycles(8);
      check_val("t6_dummy_no_drive", {31'd0, any_oe}, 32'd0);
      read_bytes(1, 1'b1, "t6");
`else
      idle_cycles(12);
      check_val("t6_no_drive", {31'd0, any_oe}, 32'd0);
`endif
      end_xfer();

      check_val("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI flash responder: the device end of the serial program-memory link that the CPU's SPI program-memory fetch logic drives. It decodes the initiator's chip-select, clock and command/address stream, serves bytes from an internal preloadable byte array, and drives the data line(s) back. It serves as an on-chip/FPGA stand-in for an external flash in self-test builds and as the bench model for fetch-path verification.

## Interface
- DEPTH, 256: bytes of backing store; power of two, 16..4096.
- AW, $clog2(DEPTH): internal address width.
- clk  in  1  system clock; must be ≥ 8× spi_sclk frequency.
- rst  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select from initiator, active-low.
- spi_sclk  in  1  serial clock, SPI mode 0 (idle low).
- spi_io0_i  in  1  MOSI / dual-data bit line 0.
- spi_io0_o  out  1  io0 drive value (dual read only).
- spi_io0_oe  out  1  io0 output enable.
- spi_io1_o  out  1  MISO / dual-data bit line 1.
- spi_io1_oe  out  1  io1 output enable.
- load_en  in  1  preload write strobe.
- load_addr  in  AW  preload address.
- load_data  in  8  preload byte.
- busy  out  1  high while spi_cs low (synchronized).

## Operation
- spi_cs, spi_sclk, spi_io0_i each pass a 2-FF synchronizer; rising/falling sclk edges and cs edges detected on synchronized copies.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- IDLE: cs falling edge → CMD, bit counter cleared.
- CMD: shift io0 on 8 sclk rising edges, MSB first. 0x03 → ADDR. Any other opcode → IGNORE.
- ADDR: shift 24 bits MSB first; only low AW bits kept (upper bits ignored, no error). After 24th rising edge fetch mem[addr] into 8-bit shift register; → DATA (or DUMMY for dual read).
- DATA (single): on each sclk falling edge drive next bit on io1, MSB first; io1_oe=1. After 8 bits, addr ← addr+1 mod DEPTH, next byte fetched, continue indefinitely.
- IGNORE: outputs disabled until cs rises.
- cs rising edge in any state → IDLE, all oe low, counters cleared; partial byte discarded. Abort mid-ADDR or mid-DATA is legal.
- sclk edges while cs high are ignored.
- Preload: load_en writes mem[load_addr] ← load_data on clk. Collision with a fetch of the same address in the same clk: fetch returns old byte.
- Memory contents not cleared by rst.

## Timing
- Reset values: spi_io0_o=0, spi_io0_oe=0, spi_io1_o=0, spi_io1_oe=0, busy=0, state=IDLE.
- Input-to-action latency: 2 clk synchronizer + 1 clk register = data line updates ≤ 3 clk after sclk falling pin edge; hence ≥ 8× clock ratio guarantees stable data before next rising edge.
- First data bit (bit7) driven on falling edge following 24th address rising edge (32nd sclk in transfer); io1_oe rises on that same falling edge.
- oe deassert ≤ 3 clk after cs rising pin edge.
- busy follows synchronized cs (2 clk lag both directions).
- Address wrap: DEPTH-1 → 0 with no gap.

## Configuration
- SPI_DUAL_READ_EN defined: opcode 0x3B accepted. After address, DUMMY for 8 sclk cycles (no drive), then DATA with 2 bits per falling edge: io1 carries bits 7,5,3,1, io0 carries bits 6,4,2,0; io0_oe and io1_oe both high; 4 sclk per byte.
- Undefined: 0x3B handled as unknown opcode (IGNORE); spi_io0_o and spi_io0_oe tied 0.

## Structure
- Shared package/defines file: opcode constants (CMD_READ=0x03, CMD_DREAD=0x3B), state encoding, address-length (24) and dummy-cycle (8) constants.
- One sub-module: spi_edge_sync (2-FF synchronizer plus rise/fall pulse outputs), instantiated for cs and sclk; io0 uses synchronizer only.

## Test plan
- Preload mem[0x10..0x13]=A5,3C,FF,00; READ 0x03 addr 0x000010, 32 data clocks → MISO bytes A5,3C,FF,00; io1_oe high from 32nd falling edge, low ≤3 clk after cs high.
- DEPTH=256, preload mem[0xFF]=11, mem[0x00]=22; READ addr 0xAB00FF, 16 data clocks → 11,22 (upper address bits ignored, wrap).
- Opcode 0x9F then 40 clocks → both oe stay 0, busy high until cs high.
- cs raised after 12 address bits, then new READ 0x000010 → A5 returned correctly (abort recovery).
- rst asserted mid-DATA → all outputs 0 immediately (async); next READ after release returns correct data.
- With SPI_DUAL_READ_EN: 0x3B addr 0x000010, 8 dummy, 4 clocks → io1 bits 1,1,0,0 / io0 bits 0,0,1,1 (0xA5); without macro → no drive.
